// File: rtl/riscv_fetch_pkg.sv
// ----------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t  : fetch FSM states with their diagnostic encodings
//                    (IDLE=000, REQ=001, WAIT=010, FAULT=100)
//   FAULT_*        : fault_cause encodings
//   NOP_INSTR      : IR contents after reset (addi x0, x0, 0)
//   *_LSB / *_MSB  : bit positions of the opcode, funct3 and funct7 fields
// ----------------------------------------------------------------------------
package riscv_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_REQ   = 3'b001,
        ST_WAIT  = 3'b010,
        ST_FAULT = 3'b100
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/fetch_timeout_counter.sv
// ----------------------------------------------------------------------------
// fetch_timeout_counter
// Counts cycles spent waiting for an instruction-memory response.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   en_i   : count this cycle (fetch FSM is in WAIT)
//   clr_i  : restart from zero (WAIT is being entered)
//   tc_o   : terminal count; high during the LIMIT-th enabled cycle
// ----------------------------------------------------------------------------
module fetch_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of enabled cycles already completed, so the
    // LIMIT-th cycle is the one that sees LIMIT-1.
    assign tc_o = en_i && (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage feeding the multicycle controller. Holds the fetch PC, issues
// one instruction-memory read per fetch_req, latches the returned word into
// the IR and presents its decoded fields.
//
// Ports:
//   clk, rst (async, active-low)
//   fetch_req                         : controller pulse, fetch next instr
//   redirect_valid / redirect_pc      : jump/branch target load
//   imem_req_valid/ready, imem_addr   : memory request channel
//   imem_rsp_valid, imem_rsp_data     : memory response channel
//   instr_valid                       : one-cycle pulse, IR updated
//   ir_31_0, opcode, funct3, funct7   : latched instruction and fields
//   pc, pc_plus4                      : address of IR instruction, +4
//   busy, fault, fault_cause          : status
//   state_vector                      : current FSM state encoding
//
// Handshake: a request is transferred on a cycle where imem_req_valid and
// imem_req_ready are both high; imem_addr is stable while valid is high and
// the request is never withdrawn. A response is accepted only in WAIT, on
// any cycle imem_rsp_valid is high (there is no response back-pressure).
//
// Build option: define FETCH_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES and
// raise a timeout fault (cause 10) when no response arrives in time.
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] ir_31_0,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [2:0]  state_vector
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pc_q, pc_d;
    logic         iv_q, iv_d;
    logic [1:0]   cause_q, cause_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  target;
    logic         tmo_tc;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (state_q == ST_WAIT),
        .clr_i  ((state_q == ST_REQ) && imem_req_ready),
        .tc_o   (tmo_tc)
    );
`else
    // Without the timeout WAIT is unbounded; keep the knobs referenced.
    logic unused_tmo;
    assign tmo_tc     = 1'b0;
    assign unused_tmo = ^{TIMEOUT_CYCLES, FAULT_TIMEOUT, tmo_tc};
`endif

    always_comb begin
        state_d   = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        iv_d      = 1'b0;
        cause_d   = cause_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        // A same-cycle redirect wins over the sequential fetch address.
        target    = redirect_valid ? redirect_pc : fetch_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (fetch_req) begin
                    if (target[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                        cause_d = FAULT_MISALIGN;
                    end else begin
                        state_d = ST_REQ;
                        addr_d  = target;
                        pend_d  = 1'b0;
                    end
                end else if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end
            end

            ST_REQ: begin
                if (redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                    if (pend_q || redirect_valid) begin
                        // Response belongs to the wrong path: drop it.
                        fetch_pc_d = redirect_valid ? redirect_pc : pend_pc_q;
                    end else begin
                        ir_d       = imem_rsp_data;
                        pc_d       = addr_q;
                        fetch_pc_d = addr_q + 32'd4;
                        iv_d       = 1'b1;
                    end
                end else if (tmo_tc) begin
                    state_d = ST_FAULT;
                    cause_d = FAULT_TIMEOUT;
                    pend_d  = 1'b0;
                end
            end

            ST_FAULT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    cause_d    = FAULT_NONE;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_q       <= NOP_INSTR;
            pc_q       <= RESET_PC;
            iv_q       <= 1'b0;
            cause_q    <= FAULT_NONE;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            iv_q       <= iv_d;
            cause_q    <= cause_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_addr      = addr_q;
    assign instr_valid    = iv_q;
    assign ir_31_0        = ir_q;
    assign opcode         = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign funct3         = ir_q[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7         = ir_q[FUNCT7_MSB:FUNCT7_LSB];
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign busy           = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign fault          = (state_q == ST_FAULT);
    assign fault_cause    = cause_q;
    assign state_vector   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed vector table for normal fetches plus hand-written sequences for
// misalignment, redirect-while-busy, reset mid-transaction, ready/response
// overlap and (when FETCH_TIMEOUT_EN is defined) the response timeout.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_REQ   = 3'b001;
    localparam logic [2:0] S_WAIT  = 3'b010;
    localparam logic [2:0] S_FAULT = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] ir_31_0;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [2:0]  state_vector;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .ir_31_0        (ir_31_0),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .busy           (busy),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .state_vector   (state_vector)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic redirect_idle(input logic [31:0] target);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("redirect_idle_state", 32'(state_vector), 32'(S_IDLE));
    endtask

    // One complete fetch: request held rdly cycles before ready, response
    // sdly cycles after WAIT entry.
    task automatic fetch_txn(input logic [31:0] exp_addr, input int rdly,
                             input int sdly, input logic [31:0] data);
        logic stable;
        logic quiet;
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_addr, exp_addr);
        stable = 1'b1;
        repeat (rdly) begin
            @(negedge clk);
            if (imem_addr !== exp_addr || imem_req_valid !== 1'b1) stable = 1'b0;
        end
        check("req_addr_stable", 32'(stable), 32'd1);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_state", 32'(state_vector), 32'(S_WAIT));
        quiet = 1'b1;
        repeat (sdly) begin
            @(negedge clk);
            if (instr_valid !== 1'b0 || state_vector !== S_WAIT) quiet = 1'b0;
        end
        check("wait_quiet", 32'(quiet), 32'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("instr_valid_pulse", 32'(instr_valid), 32'd1);
        check("ir_loaded", ir_31_0, data);
        check("back_idle", 32'(state_vector), 32'(S_IDLE));
        @(negedge clk);
        check("instr_valid_once", 32'(instr_valid), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] data;
        int          rdly;
        int          sdly;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] pc4;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 0, 0, 7'h13, 3'd0, 7'h00, 32'h0000_0004};
        vecs[1] = '{32'h0000_0100, 32'h4020_80B3, 5, 2, 7'h33, 3'd0, 7'h20, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0020_A023, 1, 3, 7'h23, 3'd2, 7'h00, 32'h0000_0000};
        vecs[3] = '{32'h0000_0040, 32'hFFF3_7313, 2, 0, 7'h13, 3'd7, 7'h7F, 32'h0000_0044};
`ifdef FETCH_TIMEOUT_EN
        vecs[4] = '{32'h0000_0080, 32'h0000_006F, 0, 5, 7'h6F, 3'd0, 7'h00, 32'h0000_0084};
`else
        vecs[4] = '{32'h0000_0080, 32'h0000_006F, 0, 39, 7'h6F, 3'd0, 7'h00, 32'h0000_0084};
`endif

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state_vector), 32'(S_IDLE));
        check("rst_ir", ir_31_0, 32'h0000_0013);
        check("rst_opcode", 32'(opcode), 32'h13);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_flags", {27'b0, imem_req_valid, instr_valid, busy, fault_cause}, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b1;

        // ---------------- table-driven fetches ----------------
        for (int i = 0; i < 5; i++) begin
            redirect_idle(vecs[i].start_pc);
            fetch_txn(vecs[i].start_pc, vecs[i].rdly, vecs[i].sdly, vecs[i].data);
            check("vec_opcode", 32'(opcode), 32'(vecs[i].op));
            check("vec_funct3", 32'(funct3), 32'(vecs[i].f3));
            check("vec_funct7", 32'(funct7), 32'(vecs[i].f7));
            check("vec_pc", pc, vecs[i].start_pc);
            check("vec_pc_plus4", pc_plus4, vecs[i].pc4);
            // Sequential follow-up fetch must use pc + 4 (wrapping).
            fetch_txn(vecs[i].pc4, 0, 0, 32'h0000_0013);
            check("vec_next_pc", pc, vecs[i].pc4);
        end

        // ---------------- misaligned redirect + fetch ----------------
        @(negedge clk);
        fetch_req      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(negedge clk);
        fetch_req      = 1'b0;
        redirect_valid = 1'b0;
        check("mis_state", 32'(state_vector), 32'(S_FAULT));
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_cause", 32'(fault_cause), 32'd1);
        check("mis_no_req", 32'(imem_req_valid), 32'd0);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("mis_fetch_ignored", 32'(state_vector), 32'(S_FAULT));
        redirect_idle(32'h0000_0100);
        check("mis_cleared", {30'b0, fault, |fault_cause}, 32'h0);
        fetch_txn(32'h0000_0100, 0, 0, 32'h00A0_0093);

        // ---------------- redirect while busy ----------------
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("redir_still_wait", 32'(state_vector), 32'(S_WAIT));
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("redir_no_iv", 32'(instr_valid), 32'd0);
        check("redir_ir_kept", ir_31_0, 32'h00A0_0093);
        check("redir_pc_kept", pc, 32'h0000_0100);
        check("redir_idle", 32'(state_vector), 32'(S_IDLE));
        fetch_txn(32'h0000_0200, 0, 0, 32'h0000_0513);

        // ---------------- response together with ready is ignored ----------------
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req      = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0000;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        check("overlap_wait", 32'(state_vector), 32'(S_WAIT));
        check("overlap_no_iv", 32'(instr_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0193;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("overlap_iv", 32'(instr_valid), 32'd1);
        check("overlap_ir", ir_31_0, 32'h0010_0193);
        check("overlap_pc", pc, 32'h0000_0204);

        // ---------------- reset mid-transaction ----------------
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req      = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_state", 32'(state_vector), 32'(S_IDLE));
        check("mid_rst_ir", ir_31_0, 32'h0000_0013);
        @(negedge clk);
        rst            = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("late_rsp_no_iv", 32'(instr_valid), 32'd0);
        check("late_rsp_ir", ir_31_0, 32'h0000_0013);
        check("late_rsp_idle", 32'(state_vector), 32'(S_IDLE));
        fetch_txn(32'h0000_0000, 0, 0, 32'h0000_0013);

`ifdef FETCH_TIMEOUT_EN
        // ---------------- response timeout ----------------
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req      = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        repeat (15) @(negedge clk);
        check("tmo_still_wait", 32'(state_vector), 32'(S_WAIT));
        @(negedge clk);
        check("tmo_fault", 32'(state_vector), 32'(S_FAULT));
        check("tmo_cause", 32'(fault_cause), 32'd2);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("tmo_late_ignored", 32'(instr_valid), 32'd0);
        check("tmo_ir_kept", ir_31_0, 32'h0000_0013);
        redirect_idle(32'h0000_0010);
        check("tmo_cleared", 32'(fault_cause), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
